// File: rtl/zbt_arbiter_pkg.sv
// zbt_arbiter_pkg: shared widths, port ids, read latency and helpers for the ZBT arbiter
package zbt_arbiter_pkg;
    localparam int LOG_ADDR   = 16;
    localparam int LOG_MEM    = 16;
    localparam int ARB_PORTS  = 3;
    localparam int ARB_RD_LAT = 3;

    typedef logic [1:0] port_t;

    localparam port_t ARB_P_DISP = 2'd0;
    localparam port_t ARB_P_CAP  = 2'd1;
    localparam port_t ARB_P_PROC = 2'd2;

    function automatic logic [ARB_PORTS-1:0] port_onehot(input port_t p);
        return ARB_PORTS'(1) << p;
    endfunction

    // Starvation counter step: clear when idle or served, otherwise count up and stick at 15.
    function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic r, input logic a);
        return (!r || a) ? 4'd0 : (c == 4'd15) ? c : c + 4'd1;
    endfunction
endpackage

// File: rtl/zbt_arb_tag_pipe.sv
// zbt_arb_tag_pipe: DEPTH-stage {valid, port} shift register that routes read returns
// Ports: clock, reset_n (async active-low), i_valid/i_port (tag loaded every cycle),
//        o_valid/o_port (tag leaving the last stage, DEPTH cycles later). DEPTH >= 2.
module zbt_arb_tag_pipe
    import zbt_arbiter_pkg::*;
#(
    parameter int DEPTH = ARB_RD_LAT
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  i_valid,
    input  port_t i_port,
    output logic  o_valid,
    output port_t o_port
);
    logic [DEPTH-1:0] r_valid;
    port_t            r_port [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_port[i] <= ARB_P_DISP;
        end else begin
            r_valid   <= {r_valid[DEPTH-2:0], i_valid};
            r_port[0] <= i_port;
            for (int i = 1; i < DEPTH; i++) r_port[i] <= r_port[i-1];
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_port  = r_port[DEPTH-1];
endmodule

// File: rtl/zbt_arbiter.sv
// zbt_arbiter: shares one ZBT SRAM port between display (0), capture (1) and processing (2)
// Ports: clock, reset_n (async active-low); req/wr per port with addr0..2, wdata1/2;
//        ack (combinational one-hot grant); rvalid/rdata (read return, 3 cycles after ack);
//        mem_wr/mem_addr/mem_write (registered ZBT command), mem_data (ZBT read data).
module zbt_arbiter
    import zbt_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [ARB_PORTS-1:0] req,
    input  logic [ARB_PORTS-1:0] wr,
    input  logic [LOG_ADDR-1:0]  addr0,
    input  logic [LOG_ADDR-1:0]  addr1,
    input  logic [LOG_ADDR-1:0]  addr2,
    input  logic [LOG_MEM-1:0]   wdata1,
    input  logic [LOG_MEM-1:0]   wdata2,
    output logic [ARB_PORTS-1:0] ack,
    output logic [ARB_PORTS-1:0] rvalid,
    output logic [LOG_MEM-1:0]   rdata,
    output logic                 mem_wr,
    output logic [LOG_ADDR-1:0]  mem_addr,
    output logic [LOG_MEM-1:0]   mem_write,
    input  logic [LOG_MEM-1:0]   mem_data
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]          r_cnt1;
    logic [3:0]          r_cnt2;
    port_t               r_last_rr;
    logic                w_st1;
    logic                w_st2;
    logic                w_gv;
    logic                w_gwr;
    logic                w_tv;
    port_t               w_rr;
    port_t               w_gp;
    port_t               w_tp;
    logic [LOG_ADDR-1:0] w_gaddr;
    logic [LOG_MEM-1:0]  w_gdata;

    // Starving ports beat port 0; otherwise port 0 first, then round-robin between 1 and 2.
    always_comb begin
        w_st1   = req[1] && r_cnt1 >= LIMIT;
        w_st2   = req[2] && r_cnt2 >= LIMIT;
        w_rr    = (r_last_rr == ARB_P_CAP) ? ARB_P_PROC : ARB_P_CAP;
        w_gp    = (w_st1 && w_st2)    ? w_rr       :
                  w_st1               ? ARB_P_CAP  :
                  w_st2               ? ARB_P_PROC :
                  req[0]              ? ARB_P_DISP :
                  (req[1] && req[2])  ? w_rr       :
                  req[1]              ? ARB_P_CAP  : ARB_P_PROC;
        // Requests are ignored while reset is held so nobody sees a phantom ack.
        w_gv    = reset_n && |req;
        ack     = w_gv ? port_onehot(w_gp) : '0;
        w_gwr   = |(ack & wr & 3'b110);
        w_gaddr = ack[1] ? addr1 : ack[2] ? addr2 : addr0;
        w_gdata = ack[1] ? wdata1 : wdata2;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt1    <= '0;
            r_cnt2    <= '0;
            r_last_rr <= ARB_P_PROC;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_write <= '0;
        end else begin
            r_cnt1    <= cnt_next(r_cnt1, req[1], ack[1]);
            r_cnt2    <= cnt_next(r_cnt2, req[2], ack[2]);
            if (ack[1] || ack[2]) r_last_rr <= w_gp;
            mem_wr    <= w_gwr;
            if (w_gv) mem_addr <= w_gaddr;
            mem_write <= w_gwr ? w_gdata : '0;
        end
    end

    zbt_arb_tag_pipe #(.DEPTH(ARB_RD_LAT)) u_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (w_gv && !w_gwr),
        .i_port  (w_gp),
        .o_valid (w_tv),
        .o_port  (w_tp)
    );

    assign rvalid = w_tv ? port_onehot(w_tp) : '0;
    assign rdata  = mem_data;
endmodule

// File: tb/tb_zbt_arbiter.sv
// tb_zbt_arbiter: randomized and directed checks of zbt_arbiter against a reference model
module tb_zbt_arbiter;
    import zbt_arbiter_pkg::*;

    localparam int STARVE = 8;

    logic                clock   = 1'b0;
    logic                reset_n = 1'b0;
    logic [2:0]          req     = '0;
    logic [2:0]          wr      = '0;
    logic [LOG_ADDR-1:0] t_addr [3] = '{default: '0};
    logic [LOG_MEM-1:0]  t_wd   [3] = '{default: '0};
    logic [2:0]          ack;
    logic [2:0]          rvalid;
    logic [LOG_MEM-1:0]  rdata;
    logic                mem_wr;
    logic [LOG_ADDR-1:0] mem_addr;
    logic [LOG_MEM-1:0]  mem_write;
    logic [LOG_MEM-1:0]  mem_data;

    zbt_arbiter #(.STARVE_LIMIT(STARVE)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .wr        (wr),
        .addr0     (t_addr[0]),
        .addr1     (t_addr[1]),
        .addr2     (t_addr[2]),
        .wdata1    (t_wd[1]),
        .wdata2    (t_wd[2]),
        .ack       (ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_data  (mem_data)
    );

    always #5 clock = ~clock;

    // ZBT model: data for a command on the bus appears two cycles later.
    logic [LOG_MEM-1:0] zmem [16] = '{default: '0};
    logic [LOG_MEM-1:0] zd1 = '0;
    logic [LOG_MEM-1:0] zd2 = '0;
    always @(posedge clock) begin
        zd2 <= zd1;
        zd1 <= zmem[mem_addr[3:0]];
        if (mem_wr) zmem[mem_addr[3:0]] <= mem_write;
    end
    assign mem_data = zd2;

    typedef struct {
        int                 due;
        int                 port;
        logic [LOG_MEM-1:0] data;
    } rd_t;

    rd_t                 q[$];
    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  cyc     = 0;
    int                  m_cnt [3] = '{0, 0, 0};
    int                  m_last  = 2;
    logic [LOG_MEM-1:0]  shadow [16] = '{default: '0};
    logic                e_wr    = 1'b0;
    logic [LOG_ADDR-1:0] e_addr  = '0;
    logic [LOG_MEM-1:0]  e_wdat  = '0;
    bit                  e_chk   = 1'b1;
    logic [2:0]          obs_ack = '0;
    logic [2:0]          obs_rv  = '0;
    logic [LOG_MEM-1:0]  obs_rd  = '0;
    logic [2:0]          rv_any;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference grant: -1 when nobody requests.
    function automatic int mgrant();
        bit s1    = req[1] && m_cnt[1] >= STARVE;
        bit s2    = req[2] && m_cnt[2] >= STARVE;
        int other = (m_last == 1) ? 2 : 1;
        if (s1 && s2) return other;
        if (s1) return 1;
        if (s2) return 2;
        if (req[0]) return 0;
        if (req[1] && req[2]) return other;
        if (req[1]) return 1;
        if (req[2]) return 2;
        return -1;
    endfunction

    task automatic step();
        int g;
        @(negedge clock);
        g = mgrant();
        check("ack", {29'd0, ack}, (g < 0) ? 0 : (1 << g));
        check("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
        if (e_chk) check("mem_write", {16'd0, mem_write}, {16'd0, e_wdat});
        if (q.size() > 0 && q[0].due == cyc) begin
            check("rvalid", {29'd0, rvalid}, 1 << q[0].port);
            check("rdata", {16'd0, rdata}, {16'd0, q[0].data});
            void'(q.pop_front());
        end else begin
            check("rvalid_idle", {29'd0, rvalid}, 0);
        end
        obs_ack = ack;
        obs_rv  = rvalid;
        obs_rd  = rdata;
        for (int p = 1; p < 3; p++)
            m_cnt[p] = (!req[p] || g == p) ? 0 : (m_cnt[p] == 15 ? 15 : m_cnt[p] + 1);
        if (g > 0) m_last = g;
        if (g < 0) begin
            e_wr   = 1'b0;
            e_wdat = '0;
            e_chk  = 1'b1;
        end else begin
            e_wr   = (g != 0) && wr[g];
            e_addr = t_addr[g];
            e_wdat = e_wr ? t_wd[g] : '0;
            e_chk  = e_wr;
            if (e_wr) shadow[t_addr[g][3:0]] = t_wd[g];
            else q.push_back('{due: cyc + 3, port: g, data: shadow[t_addr[g][3:0]]});
        end
        cyc++;
        @(posedge clock);
        #1;
        req = req & ~obs_ack;
    endtask

    task automatic do_reset(input int n, input logic [2:0] rel_req);
        reset_n = 1'b0;
        req     = 3'b111;
        repeat (n) begin
            @(negedge clock);
            check("rst_ack", {29'd0, ack}, 0);
            check("rst_mem_wr", {31'd0, mem_wr}, 0);
            check("rst_rvalid", {29'd0, rvalid}, 0);
            check("rst_mem_addr", {16'd0, mem_addr}, 0);
            cyc++;
            @(posedge clock);
            #1;
        end
        m_cnt  = '{0, 0, 0};
        m_last = 2;
        e_wr   = 1'b0;
        e_addr = '0;
        e_wdat = '0;
        e_chk  = 1'b1;
        q.delete();
        req     = rel_req;
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset held with all ports requesting; port 0 wins the first cycle after release.
        t_addr[0] = 16'd9;
        t_addr[1] = 16'd10;
        t_addr[2] = 16'd11;
        do_reset(3, 3'b111);
        step();
        check("rst_first_ack", {29'd0, obs_ack}, 32'h1);
        repeat (6) step();

        // Port 1 writes 0x00AB to address 5, port 2 reads it back the next cycle.
        wr = 3'b010; t_addr[1] = 16'd5; t_wd[1] = 16'h00AB; req = 3'b010;
        step();
        wr = 3'b000; t_addr[2] = 16'd5; req = 3'b100;
        step();
        repeat (2) step();
        step();
        check("wr_rd_rvalid", {29'd0, obs_rv}, 32'h4);
        check("wr_rd_data", {16'd0, obs_rd}, 32'h00AB);
        repeat (2) step();

        // Round-robin between ports 1 and 2, starting at port 1.
        do_reset(2, 3'b000);
        wr = 3'b110; t_wd[1] = 16'h0101; t_wd[2] = 16'h0202;
        for (int i = 0; i < 4; i++) begin
            req[2:1] = 2'b11;
            step();
            check("rr_ack", {29'd0, obs_ack}, (i % 2 == 0) ? 32'h2 : 32'h4);
        end
        repeat (4) step();

        // Port 0 hammers; port 1 gets in once its wait reaches the limit.
        do_reset(2, 3'b000);
        wr = 3'b010; t_addr[0] = 16'd7; t_addr[1] = 16'd7; t_wd[1] = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            req[0] = 1'b1;
            if (i == 0) req[1] = 1'b1;
            step();
            check("starve_ack", {29'd0, obs_ack}, (i == STARVE) ? 32'h2 : 32'h1);
        end
        repeat (4) step();

        // Seed addresses 1..3, then read them back from mixed ports in order.
        wr = 3'b010;
        for (int i = 1; i <= 3; i++) begin
            t_addr[1] = 16'(i); t_wd[1] = 16'(i * 16'h1111); req = 3'b010;
            step();
        end
        wr = 3'b000;
        t_addr[0] = 16'd1; req = 3'b001; step();
        t_addr[2] = 16'd2; req = 3'b100; step();
        t_addr[0] = 16'd3; req = 3'b001; step();
        step();
        check("ord_rv0", {29'd0, obs_rv}, 32'h1);
        check("ord_rd0", {16'd0, obs_rd}, 32'h1111);
        step();
        check("ord_rv1", {29'd0, obs_rv}, 32'h4);
        check("ord_rd1", {16'd0, obs_rd}, 32'h2222);
        step();
        check("ord_rv2", {29'd0, obs_rv}, 32'h1);
        check("ord_rd2", {16'd0, obs_rd}, 32'h3333);
        repeat (2) step();

        // Reset one cycle after a read ack drops that read.
        wr = 3'b000; t_addr[0] = 16'd4; req = 3'b001;
        step();
        do_reset(2, 3'b000);
        rv_any = '0;
        repeat (6) begin
            step();
            rv_any = rv_any | obs_rv;
        end
        check("mid_rst_rv", {29'd0, rv_any}, 0);

        // Random traffic with varying request density.
        for (int i = 0; i < 3000; i++) begin
            int dens = (i / 500) % 4;
            for (int p = 0; p < 3; p++) begin
                if (!req[p] && $urandom_range(0, 3) <= dens) begin
                    req[p]    = 1'b1;
                    wr[p]     = 1'($urandom_range(0, 1));
                    t_addr[p] = LOG_ADDR'($urandom_range(0, 15));
                    t_wd[p]   = LOG_MEM'($urandom);
                end
            end
            step();
        end
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
